// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP adder scheduler: FSM states,
// IEEE-754 single field positions, flag bit order and the signed-zero helpers.
package fp_sched_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FLAG_W   = 3;

   localparam int OVF = 2;
   localparam int UNF = 1;
   localparam int EXC = 0;

   // +0 or -0: exponent and mantissa both clear, sign ignored
   function automatic logic is_zero(logic [31:0] v);
      return v[EXP_MSB:0] == '0;
   endfunction

   // Sum when at least one operand is a signed zero; -0 only for (-0)+(-0)
   function automatic logic [31:0] zero_sum(logic [31:0] a, logic [31:0] b);
      if (is_zero(a) && is_zero(b))
         return {a[SIGN_BIT] & b[SIGN_BIT], 31'b0};
      else if (is_zero(a))
         return b;
      else
         return a;
   endfunction

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N; returns one-hot grant, its index and an any-flag.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // Walk from farthest to nearest so the nearest valid requester wins
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = $clog2(N)'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_scheduler.sv
// Time-shares one combinational FP32 adder among NUM_REQ requesters.
// Define FP_SCHED_ZERO_BYPASS_EN to answer ops with a +/-0 operand without the adder.
module fp_add_scheduler #(
   parameter int XLEN        = 32,
   parameter int NUM_REQ     = 4,
   parameter int ADD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_a,
   input  logic [NUM_REQ*XLEN-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_sub,
   output logic [XLEN-1:0]         add_a,
   output logic [XLEN-1:0]         add_b,
   input  logic [XLEN-1:0]         add_result,
   input  logic                    add_overflow,
   input  logic                    add_underflow,
   input  logic                    add_exception,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [XLEN-1:0]         resp_result,
   output logic [2:0]              resp_flags,
   output logic                    busy
);
   import fp_sched_pkg::*;

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

   state_t              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gnt_q, gnt_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;
   logic [XLEN-1:0]     sel_a, sel_b;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_gnt),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Effective operands of the would-be winner; B's sign pre-flipped for subtract
   assign sel_a = req_a[arb_idx*XLEN +: XLEN];
   assign sel_b = req_b[arb_idx*XLEN +: XLEN] ^ {req_sub[arb_idx], {(XLEN-1){1'b0}}};

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      flags_d    = flags_q;
      req_ready  = '0;
      resp_valid = '0;
      add_a      = '0;
      add_b      = '0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               req_ready = arb_gnt;
               a_d       = sel_a;
               b_d       = sel_b;
               gnt_d     = arb_idx;
               cnt_d     = CW'(ADD_LATENCY - 1);
               state_d   = WAIT;
`ifdef FP_SCHED_ZERO_BYPASS_EN
               if (is_zero(sel_a) || is_zero(sel_b)) begin
                  res_d   = zero_sum(sel_a, sel_b);
                  flags_d = '0;
                  state_d = RESP;
               end
`endif
            end
         end
         WAIT: begin
            add_a = a_q;
            add_b = b_q;
            if (cnt_q == '0) begin
               res_d        = add_result;
               flags_d[OVF] = add_overflow;
               flags_d[UNF] = add_underflow;
               flags_d[EXC] = add_exception;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            resp_valid[gnt_q] = 1'b1;
            // Pointer moves only on completion so waiting requesters keep their turn
            if (resp_ready[gnt_q]) begin
               state_d = IDLE;
               ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign resp_result = res_q;
   assign resp_flags  = flags_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a table-driven stand-in adder.
module tb_fp_add_scheduler;

   localparam int NR  = 4;
   localparam int LAT = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid, req_ready, req_sub, resp_valid, resp_ready;
   logic [NR*32-1:0]  req_a, req_b;
   logic [31:0]       add_a, add_b, add_result, resp_result;
   logic              add_overflow, add_underflow, add_exception, busy;
   logic [2:0]        resp_flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_add_scheduler #(.XLEN(32), .NUM_REQ(NR), .ADD_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .add_a(add_a), .add_b(add_b), .add_result(add_result),
      .add_overflow(add_overflow), .add_underflow(add_underflow),
      .add_exception(add_exception),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
   );

   // Stand-in adder: known sums for the directed vectors, XOR otherwise
   always_comb begin
      add_result    = add_a ^ add_b;
      add_overflow  = 1'b0;
      add_underflow = 1'b0;
      add_exception = 1'b0;
      case ({add_a, add_b})
         {32'h3F800000, 32'h40000000}: add_result = 32'h40400000;
         {32'h40400000, 32'hBF800000}: add_result = 32'h40000000;
         {32'h7F7FFFFF, 32'h7F7FFFFF}: begin
            add_result   = 32'h7F800000;
            add_overflow = 1'b1;
         end
         {32'h00800001, 32'h80800000}: begin
            add_result    = 32'h00000001;
            add_underflow = 1'b1;
            add_exception = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_sub[i]        = s;
   endtask

   // Called at the negedge of the grant cycle with resp_ready already high
   task automatic do_op(input int g, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] er, input logic [2:0] ef);
      #1;
      chk("grant", 32'(req_ready), 32'(1 << g));
      chk("idle_busy", 32'(busy), 32'd0);
      @(negedge clk); #1;
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      chk("wait_ready", 32'(req_ready), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
      chk("resp_valid", 32'(resp_valid), 32'(1 << g));
      chk("resp_result", resp_result, er);
      chk("resp_flags", 32'(resp_flags), 32'(ef));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_sub = '0; resp_ready = '0;
      req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rvalid", 32'(resp_valid), 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_add_b", add_b, 32'd0);
      chk("rst_result", resp_result, 32'd0);
      chk("rst_flags", 32'(resp_flags), 32'd0);
      rst = 1'b0;

      // 1.0 + 2.0 on requester 0
      @(negedge clk);
      set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
      req_valid = 4'b0001; resp_ready = 4'b1111;
      do_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
      req_valid = '0;

      // 3.0 - 1.0 on requester 2 (pointer now 1)
      set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
      req_valid = 4'b0100;
      do_op(2, 32'h40400000, 32'hBF800000, 32'h40000000, 3'b000);
      req_valid = '0;

      // Overflow on requester 1 (wraps from pointer 3) with held backpressure
      set_op(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
      req_valid = 4'b0010; resp_ready = '0;
      #1 chk("bp_grant", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b1111;
      #1 chk("bp_add_a", add_a, 32'h7F7FFFFF);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_rvalid", 32'(resp_valid), 32'b0010);
         chk("bp_result", resp_result, 32'h7F800000);
         chk("bp_flags", 32'(resp_flags), 32'b100);
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      resp_ready = 4'b0010; req_valid = '0;
      @(negedge clk); #1;
      chk("bp_done_busy", 32'(busy), 32'd0);
      chk("bp_done_rvalid", 32'(resp_valid), 32'd0);

      // Reset while requester 3 (pointer 2) is in WAIT
      resp_ready = 4'b1111;
      set_op(3, 32'h41000003, 32'h00000100, 1'b0);
      req_valid = 4'b1000;
      #1 chk("rw_grant", 32'(req_ready), 32'b1000);
      @(negedge clk);
      rst = 1'b1; req_valid = '0;
      @(negedge clk); #1;
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_ready", 32'(req_ready), 32'd0);
      chk("rw_rvalid", 32'(resp_valid), 32'd0);
      chk("rw_add_a", add_a, 32'd0);
      chk("rw_add_b", add_b, 32'd0);
      chk("rw_result", resp_result, 32'd0);
      chk("rw_flags", 32'(resp_flags), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < NR; i++) set_op(i, 32'h41000000 + 32'(i), 32'h00000100, 1'b0);
      // Requester 1 must win over 3, proving the pointer restarted at 0
      req_valid = 4'b1010;
      do_op(1, 32'h41000001, 32'h00000100, 32'h41000101, 3'b000);
      do_op(3, 32'h41000003, 32'h00000100, 32'h41000103, 3'b000);

      // All requesters valid: order 0,1,2,3,0 at one op every three cycles
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++)
         do_op(k % NR, 32'h41000000 + 32'(k % NR), 32'h00000100,
               32'h41000100 + 32'(k % NR), 3'b000);
      req_valid = '0;

      // Subtract producing underflow+exception on requester 2 (pointer 1)
      set_op(2, 32'h00800001, 32'h00800000, 1'b1);
      req_valid = 4'b0100;
      do_op(2, 32'h00800001, 32'h80800000, 32'h00000001, 3'b011);
      req_valid = '0;

      // 0 - 1.0 on requester 3 (pointer 3)
      set_op(3, 32'h00000000, 32'h3F800000, 1'b1);
      req_valid = 4'b1000;
`ifdef FP_SCHED_ZERO_BYPASS_EN
      #1 chk("zb_grant", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("zb_rvalid", 32'(resp_valid), 32'b1000);
      chk("zb_result", resp_result, 32'hBF800000);
      chk("zb_flags", 32'(resp_flags), 32'd0);
      chk("zb_add_a", add_a, 32'd0);
      @(negedge clk); #1;
      chk("zb_busy", 32'(busy), 32'd0);
`else
      do_op(3, 32'h00000000, 32'hBF800000, 32'hBF800000, 3'b000);
      req_valid = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one single-precision FP adder datapath among NUM_REQ requesters. The adder is combinational: operands A and B in; result, overflow, underflow and exception out.
- Round-robin arbitration; one operation in flight at a time.
- Optional subtract: the block flips B's sign before issue.
- Drives the adder for a fixed settle window, captures result and flags, and returns them to the granted requester over a valid/ready response channel.

Parameters:
- XLEN, 32, operand/result width (IEEE-754 single)
- NUM_REQ, 4, number of requesters (2..8)
- ADD_LATENCY, 1, cycles adder inputs are held before result capture (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  one-hot accept; asserts only in IDLE
- req_a  in  NUM_REQ*XLEN  operand A, requester i at [i*XLEN +: XLEN]
- req_b  in  NUM_REQ*XLEN  operand B, same packing
- req_sub  in  NUM_REQ  1 = compute A-B
- add_a  out  XLEN  to adder A
- add_b  out  XLEN  to adder B (sign already adjusted)
- add_result  in  XLEN  adder result
- add_overflow, add_underflow, add_exception  in  1 each  adder flags
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_ready  in  NUM_REQ  response accept
- resp_result  out  XLEN  captured result
- resp_flags  out  3  {overflow, underflow, exception}
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr pointer=0, grant register=0, latency counter=0, operand/result/flag registers=0.
  - All outputs then read 0: req_ready, resp_valid, add_a, add_b, resp_result, resp_flags, busy.
  - Reset mid-operation discards the in-flight op; no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid: round-robin grant g = first valid index at or after the pointer, wrapping mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Latch A_g and B_g. If req_sub[g], latch B with bit XLEN-1 inverted. Latch g.
  - counter = ADD_LATENCY-1; next state WAIT.
  - No valid: stay IDLE.
- WAIT:
  - add_a/add_b driven from the latched registers (held stable; 0 outside WAIT).
  - Counter decrements each cycle. In the cycle counter==0, capture add_result and flags, then go to RESP.
- RESP:
  - resp_valid[g]=1; result and flags held stable.
  - On resp_ready[g]: go to IDLE, pointer = (g+1) mod NUM_REQ.
  - Backpressure is unbounded; the block stays in RESP until accepted.
- Latency: handshake in cycle T; resp_valid first high in cycle T+ADD_LATENCY+1. Minimum throughput is one op per ADD_LATENCY+2 cycles.
- Requesters must hold req_valid and their operands stable until req_ready. req_valid deasserting before grant is legal (request withdrawn).
- Requests arriving while busy are not accepted; req_ready stays 0 outside IDLE.
- Responses are never reordered or lost.
- Pointer updates only on response completion, so every persistently valid requester is served within NUM_REQ operations.

Optional Feature:
- Macro FP_SCHED_ZERO_BYPASS_EN.
- Defined: in IDLE, if the accepted effective A or B has a zero exponent and zero mantissa (±0), the block skips WAIT and goes directly to RESP.
  - Result is the other operand, with the effective (possibly flipped) B sign when A is zero.
  - Both zero: result -0 only when both effective signs are negative, else +0.
  - Flags = 0. resp_valid appears at T+1.
- Undefined: all ops use the adder path with full latency.

Decomposition:
- Package fp_sched_pkg:
  - state enum {IDLE, WAIT, RESP}
  - SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, FLAG_W=3
  - flag index constants OVF=2, UNF=1, EXC=0
- Sub-module rr_arbiter:
  - param N
  - inputs: req, ptr
  - output: one-hot grant plus index
  - purely combinational

Test Plan:
1. Req0 A=0x3F800000 (1.0), B=0x40000000 (2.0), sub=0, ADD_LATENCY=1 with a behavioural adder -> req_ready[0] in cycle T; add_a/add_b match in T+1; resp_valid[0] in T+2; resp_result=0x40400000; flags=0.
2. Req2 A=0x40400000, B=0x3F800000, sub=1 -> add_b=0xBF800000; resp_result=0x40000000.
3. All four requesters continuously valid, resp_ready=1 -> grant order 0,1,2,3,0; each completion spaced exactly 3 cycles.
4. Hold resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_result stable throughout; req_ready=0 for every requester; busy=1.
5. Assert rst in WAIT -> next cycle all outputs 0 and state IDLE; the pending requester is re-granted from pointer 0 and no stale response appears.
6. FP_SCHED_ZERO_BYPASS_EN defined, A=0x00000000, B=0x3F800000, sub=1 -> resp_result=0xBF800000 at T+1; add_a stays 0.
